ddram_arbiter: RTL and testbench
================================

# ddram_arbiter

Two-port arbiter that shares the single MiSTer DDRAM Avalon-style port between the CPU/DMA cache (port A) and a secondary DDRAM client (port B). Typical B clients are a framebuffer reader or a disk-image streamer. It grants whole transactions (one read command with its full return burst, or one complete write burst) in round-robin order. It routes read-return beats only to the owning port. It sits between the cache/clients and the top-level DDRAM pins, clocked by clk_sys.

## Interface
- AW, 29, address width of all ports (DDRAM word address).
- clk_sys  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- Per port X∈{a,b}:
  - X_addr  in  AW  command address.
  - X_burstcnt  in  8  beats in burst.
  - X_rd  in  1  read command.
  - X_we  in  1  write command/beat.
  - X_din  in  64  write data.
  - X_be  in  8  byte enables.
  - X_busy  out  1  stall; a beat is accepted when X_rd|X_we high and X_busy low.
  - X_dout  out  64  read data, shared copy of DDRAM_DOUT.
  - X_dout_ready  out  1  read beat valid for this port.
- DDRAM_ADDR  out  AW
- DDRAM_BURSTCNT  out  8
- DDRAM_DIN  out  64
- DDRAM_BE  out  8
- DDRAM_RD  out  1
- DDRAM_WE  out  1
- DDRAM_BUSY  in  1
- DDRAM_DOUT  in  64
- DDRAM_DOUT_READY  in  1

## Operation
- States: IDLE, GNT (command phase), WBURST (write continuation), RWAIT (read return). Register owner∈{A,B} and last_gnt.
- IDLE:
  - DDRAM_RD=DDRAM_WE=0; a_busy=b_busy=1.
  - If any X_rd|X_we is high, go to GNT with owner chosen as follows.
    - Only one port requests: owner is that port.
    - Both request: owner is the port ≠ last_gnt.
  - Set last_gnt=owner on entry to GNT.
- GNT:
  - DDRAM_ADDR/BURSTCNT/DIN/BE come from the owner.
  - owner_busy=DDRAM_BUSY; the other port's busy=1.
  - If owner_we: DDRAM_WE=1, DDRAM_RD=0. we wins if rd and we are both high; rd is dropped.
    - On acceptance (~DDRAM_BUSY), latch burstcnt into cnt.
    - cnt==1 → IDLE; else cnt−1 → WBURST.
  - Else if owner_rd: DDRAM_RD=1.
    - On acceptance, latch burstcnt into cnt → RWAIT.
  - Else (owner withdrew request) → IDLE with no command issued.
- WBURST:
  - DDRAM_WE=owner_we; DDRAM_RD=0.
  - Data/BE come from the owner; DDRAM_BURSTCNT and DDRAM_ADDR hold the latched values.
  - Each accepted beat decrements cnt; the beat at cnt==1 → IDLE.
  - Owner deasserting we stalls the burst indefinitely; there is no timeout.
- RWAIT:
  - DDRAM_RD=DDRAM_WE=0; both busy=1.
  - Each DDRAM_DOUT_READY decrements cnt; the beat at cnt==1 → IDLE.
- X_dout_ready = DDRAM_DOUT_READY & (state==RWAIT) & (owner==X).
- X_dout = DDRAM_DOUT, always.
- Burst count 0 is treated as 1.
- cnt is 9 bits so 256-equivalent values never wrap.
- Reset:
  - state=IDLE, cnt=0, owner=A, last_gnt=B (A wins the first tie).
  - Outputs: DDRAM_RD=0, DDRAM_WE=0, a_busy=b_busy=1, X_dout_ready=0.
  - Reset mid-transaction abandons the transaction.
  - Read beats arriving after reset are discarded: dout_ready stays 0 because state is IDLE.

## Timing
- Arbitration latency is 1 cycle. A request first seen in IDLE at cycle n gives GNT at n+1. The owner's busy follows DDRAM_BUSY from n+1.
- Busy is combinational from DDRAM_BUSY in GNT/WBURST. All other outputs to masters are combinational muxes on the registered state/owner.
- Return to IDLE happens the cycle after the last write beat or last read beat. Back-to-back transactions therefore have a ≥2-cycle gap (IDLE, GNT).
- Only one transaction is outstanding at a time. No new command is issued until read return completes.
- A request arriving during another port's transaction waits. Round robin guarantees it the next grant.

## Test plan
- Both ports assert rd in the same cycle after reset → A granted first (burst 1). B is granted after A's beat returns; a_dout_ready and b_dout_ready each pulse exactly once.
- A read burst 4 at addr 0x100, DDRAM returns 4 beats with gaps → a_dout_ready pulses 4×, b_dout_ready stays 0, state IDLE the cycle after the 4th beat.
- B write burst 3 with DDRAM_BUSY high for 2 cycles on beat 2 → DDRAM_WE/DIN track B. Exactly 3 beats are accepted, DDRAM_ADDR holds the first address, and A stays busy throughout.
- Reset asserted in RWAIT after 1 of 4 beats, remaining 3 beats delivered → no dout_ready pulses. Both busy=1 during reset, then a fresh grant to A on the next request.
- A asserts rd and we together, burstcnt 1 → DDRAM_WE=1, DDRAM_RD=0, and the transaction completes as a single-beat write.
- A continuous requests while B requests once → grant sequence A, B, A. B waits at most one A transaction.

Source files
------------

// File: rtl/ddram_arbiter.sv
// Two-port round-robin arbiter for the MiSTer DDRAM port: grants whole read or write
// transactions to port A (cache/DMA) or port B, and steers read-return beats to the owner.
module ddram_arbiter #(
    parameter int AW = 29
) (
    input  logic          clk_sys,
    input  logic          reset,

    input  logic [AW-1:0] a_addr,
    input  logic [7:0]    a_burstcnt,
    input  logic          a_rd,
    input  logic          a_we,
    input  logic [63:0]   a_din,
    input  logic [7:0]    a_be,
    output logic          a_busy,
    output logic [63:0]   a_dout,
    output logic          a_dout_ready,

    input  logic [AW-1:0] b_addr,
    input  logic [7:0]    b_burstcnt,
    input  logic          b_rd,
    input  logic          b_we,
    input  logic [63:0]   b_din,
    input  logic [7:0]    b_be,
    output logic          b_busy,
    output logic [63:0]   b_dout,
    output logic          b_dout_ready,

    output logic [AW-1:0] DDRAM_ADDR,
    output logic [7:0]    DDRAM_BURSTCNT,
    output logic [63:0]   DDRAM_DIN,
    output logic [7:0]    DDRAM_BE,
    output logic          DDRAM_RD,
    output logic          DDRAM_WE,
    input  logic          DDRAM_BUSY,
    input  logic [63:0]   DDRAM_DOUT,
    input  logic          DDRAM_DOUT_READY
);

    typedef enum logic [1:0] {S_IDLE, S_GNT, S_WBURST, S_RWAIT} state_t;

    state_t        r_state, w_state_nxt;
    logic          r_owner, w_owner_nxt;   // 0 = A, 1 = B
    logic          r_last,  w_last_nxt;
    logic [8:0]    r_cnt,   w_cnt_nxt;
    logic [AW-1:0] r_addr,  w_addr_nxt;
    logic [7:0]    r_bcnt,  w_bcnt_nxt;

    logic          w_req_a, w_req_b;
    logic [AW-1:0] w_o_addr;
    logic [7:0]    w_o_bcnt;
    logic          w_o_rd, w_o_we;
    logic [63:0]   w_o_din;
    logic [7:0]    w_o_be;
    logic [8:0]    w_bc9;
    logic          w_own_busy;

    assign w_req_a  = a_rd | a_we;
    assign w_req_b  = b_rd | b_we;
    assign w_o_addr = r_owner ? b_addr     : a_addr;
    assign w_o_bcnt = r_owner ? b_burstcnt : a_burstcnt;
    assign w_o_rd   = r_owner ? b_rd       : a_rd;
    assign w_o_we   = r_owner ? b_we       : a_we;
    assign w_o_din  = r_owner ? b_din      : a_din;
    assign w_o_be   = r_owner ? b_be       : a_be;
    // A zero burst count moves one beat.
    assign w_bc9    = (w_o_bcnt == 8'd0) ? 9'd1 : {1'b0, w_o_bcnt};

    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_last_nxt     = r_last;
        w_cnt_nxt      = r_cnt;
        w_addr_nxt     = r_addr;
        w_bcnt_nxt     = r_bcnt;
        w_own_busy     = 1'b1;
        DDRAM_RD       = 1'b0;
        DDRAM_WE       = 1'b0;
        DDRAM_ADDR     = r_addr;
        DDRAM_BURSTCNT = r_bcnt;
        DDRAM_DIN      = w_o_din;
        DDRAM_BE       = w_o_be;
        case (r_state)
            S_IDLE: begin
                if (w_req_a || w_req_b) begin
                    w_state_nxt = S_GNT;
                    w_owner_nxt = (w_req_a && w_req_b) ? ~r_last : w_req_b;
                    w_last_nxt  = w_owner_nxt;
                end
            end
            S_GNT: begin
                DDRAM_ADDR     = w_o_addr;
                DDRAM_BURSTCNT = w_o_bcnt;
                w_own_busy     = DDRAM_BUSY;
                if (w_o_we) begin
                    DDRAM_WE = 1'b1;
                    if (!DDRAM_BUSY) begin
                        w_addr_nxt  = w_o_addr;
                        w_bcnt_nxt  = w_o_bcnt;
                        w_cnt_nxt   = w_bc9 - 9'd1;
                        w_state_nxt = (w_bc9 == 9'd1) ? S_IDLE : S_WBURST;
                    end
                end else if (w_o_rd) begin
                    DDRAM_RD = 1'b1;
                    if (!DDRAM_BUSY) begin
                        w_addr_nxt  = w_o_addr;
                        w_bcnt_nxt  = w_o_bcnt;
                        w_cnt_nxt   = w_bc9;
                        w_state_nxt = S_RWAIT;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WBURST: begin
                DDRAM_WE   = w_o_we;
                w_own_busy = DDRAM_BUSY;
                if (w_o_we && !DDRAM_BUSY) begin
                    w_cnt_nxt = r_cnt - 9'd1;
                    if (r_cnt <= 9'd1) w_state_nxt = S_IDLE;
                end
            end
            S_RWAIT: begin
                if (DDRAM_DOUT_READY) begin
                    w_cnt_nxt = r_cnt - 9'd1;
                    if (r_cnt <= 9'd1) w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_cnt   <= 9'd0;
            r_addr  <= '0;
            r_bcnt  <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_addr  <= w_addr_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    assign a_busy       = r_owner ? 1'b1 : w_own_busy;
    assign b_busy       = r_owner ? w_own_busy : 1'b1;
    assign a_dout       = DDRAM_DOUT;
    assign b_dout       = DDRAM_DOUT;
    assign a_dout_ready = DDRAM_DOUT_READY && (r_state == S_RWAIT) && !r_owner;
    assign b_dout_ready = DDRAM_DOUT_READY && (r_state == S_RWAIT) &&  r_owner;

endmodule

// File: tb/tb_ddram_arbiter.sv
// Bench for ddram_arbiter: cycle vector table plus hand sequences, with a scoreboard
// of expected DDRAM commands/write beats and per-port read returns.
module tb_ddram_arbiter;
    localparam int AW = 29;
    localparam int K_RC = 0, K_WB = 1, K_RA = 2, K_RB = 3;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [AW-1:0] a_addr, b_addr;
    logic [7:0]    a_burstcnt, b_burstcnt;
    logic          a_rd, a_we, b_rd, b_we;
    logic [63:0]   a_din, b_din;
    logic [7:0]    a_be, b_be;
    logic          a_busy, b_busy, a_dout_ready, b_dout_ready;
    logic [63:0]   a_dout, b_dout;
    logic [AW-1:0] DDRAM_ADDR;
    logic [7:0]    DDRAM_BURSTCNT, DDRAM_BE;
    logic [63:0]   DDRAM_DIN, DDRAM_DOUT;
    logic          DDRAM_RD, DDRAM_WE, DDRAM_BUSY, DDRAM_DOUT_READY;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int            kind;
        logic [AW-1:0] addr;
        logic [7:0]    bc;
        logic [63:0]   data;
        logic [7:0]    be;
    } ev_t;
    ev_t q[$];

    typedef struct {
        logic        a_rd, a_we, b_rd, b_we, busy, rdy;
        logic [63:0] dout;
        logic [5:0]  exp;   // {a_busy, b_busy, RD, WE, a_dout_ready, b_dout_ready}
    } vec_t;
    vec_t vec[8];

    ddram_arbiter #(.AW(AW)) dut (
        .clk_sys(clk_sys), .reset(reset),
        .a_addr(a_addr), .a_burstcnt(a_burstcnt), .a_rd(a_rd), .a_we(a_we),
        .a_din(a_din), .a_be(a_be), .a_busy(a_busy), .a_dout(a_dout), .a_dout_ready(a_dout_ready),
        .b_addr(b_addr), .b_burstcnt(b_burstcnt), .b_rd(b_rd), .b_we(b_we),
        .b_din(b_din), .b_be(b_be), .b_busy(b_busy), .b_dout(b_dout), .b_dout_ready(b_dout_ready),
        .DDRAM_ADDR(DDRAM_ADDR), .DDRAM_BURSTCNT(DDRAM_BURSTCNT), .DDRAM_DIN(DDRAM_DIN),
        .DDRAM_BE(DDRAM_BE), .DDRAM_RD(DDRAM_RD), .DDRAM_WE(DDRAM_WE), .DDRAM_BUSY(DDRAM_BUSY),
        .DDRAM_DOUT(DDRAM_DOUT), .DDRAM_DOUT_READY(DDRAM_DOUT_READY)
    );

    always #5 clk_sys = ~clk_sys;

    function automatic logic [5:0] outs();
        return {a_busy, b_busy, DDRAM_RD, DDRAM_WE, a_dout_ready, b_dout_ready};
    endfunction

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [AW-1:0] a, input logic [7:0] bc,
                        input logic [63:0] d, input logic [7:0] be);
        q.push_back('{k, a, bc, d, be});
    endtask

    task automatic obs(input int k, input logic [AW-1:0] a, input logic [7:0] bc,
                       input logic [63:0] d, input logic [7:0] be);
        ev_t e;
        total++;
        if (q.size() == 0) begin
            bad++;
            $display("FAIL sb_unexpected: got kind=%0d addr=%0h data=%0h expected nothing", k, a, d);
        end else begin
            e = q.pop_front();
            if (e.kind != k || e.addr !== a || e.bc !== bc || e.data !== d || e.be !== be) begin
                bad++;
                $display("FAIL sb_event: got kind=%0d addr=%0h bc=%0d data=%0h be=%0h expected kind=%0d addr=%0h bc=%0d data=%0h be=%0h",
                         k, a, bc, d, be, e.kind, e.addr, e.bc, e.data, e.be);
            end
        end
    endtask

    always @(negedge clk_sys) begin
        if ((DDRAM_RD || DDRAM_WE) && !DDRAM_BUSY)
            obs(DDRAM_WE ? K_WB : K_RC, DDRAM_ADDR, DDRAM_BURSTCNT,
                DDRAM_WE ? DDRAM_DIN : 64'h0, DDRAM_WE ? DDRAM_BE : 8'h0);
        if (a_dout_ready) obs(K_RA, '0, 8'd0, a_dout, 8'h0);
        if (b_dout_ready) obs(K_RB, '0, 8'd0, b_dout, 8'h0);
    end

    // Call in GNT: the single-beat read is accepted now, its beat returns next cycle.
    task automatic fin_rd1(input bit port, input logic [AW-1:0] addr, input logic [7:0] bc,
                           input logic [63:0] d);
        push(K_RC, addr, bc, 64'h0, 8'h0);
        tick();
        if (port) b_rd = 1'b0; else a_rd = 1'b0;
        DDRAM_DOUT_READY = 1'b1;
        DDRAM_DOUT = d;
        push(port ? K_RB : K_RA, '0, 8'd0, d, 8'h0);
        tick();
        DDRAM_DOUT_READY = 1'b0;
    endtask

    initial begin
        vec[0] = '{1, 0, 1, 0, 0, 0, 64'h0,    6'b110000};
        vec[1] = '{1, 0, 1, 0, 0, 0, 64'h0,    6'b011000};
        vec[2] = '{0, 0, 1, 0, 0, 0, 64'h0,    6'b110000};
        vec[3] = '{0, 0, 1, 0, 0, 1, 64'h1111, 6'b110010};
        vec[4] = '{0, 0, 1, 0, 0, 0, 64'h0,    6'b110000};
        vec[5] = '{0, 0, 1, 0, 0, 0, 64'h0,    6'b101000};
        vec[6] = '{0, 0, 0, 0, 0, 1, 64'h2222, 6'b110001};
        vec[7] = '{0, 0, 0, 0, 0, 0, 64'h0,    6'b110000};

        reset = 1'b1;
        a_addr = '0; b_addr = '0; a_burstcnt = 8'd1; b_burstcnt = 8'd1;
        a_rd = 0; a_we = 0; b_rd = 0; b_we = 0;
        a_din = '0; b_din = '0; a_be = '0; b_be = '0;
        DDRAM_BUSY = 0; DDRAM_DOUT = '0; DDRAM_DOUT_READY = 0;
        tick();
        tick();
        chk("rst_outs", {58'h0, outs()}, 64'b110000);
        reset = 1'b0;

        // Tie after reset: A first, then B.
        a_addr = 29'h10; b_addr = 29'h20;
        push(K_RC, 29'h10, 8'd1, 64'h0, 8'h0);
        push(K_RA, '0, 8'd0, 64'h1111, 8'h0);
        push(K_RC, 29'h20, 8'd1, 64'h0, 8'h0);
        push(K_RB, '0, 8'd0, 64'h2222, 8'h0);
        for (int i = 0; i < 8; i++) begin
            a_rd = vec[i].a_rd; a_we = vec[i].a_we; b_rd = vec[i].b_rd; b_we = vec[i].b_we;
            DDRAM_BUSY = vec[i].busy; DDRAM_DOUT_READY = vec[i].rdy; DDRAM_DOUT = vec[i].dout;
            #1;
            chk($sformatf("vec%0d", i), {58'h0, outs()}, {58'h0, vec[i].exp});
            tick();
        end

        // A read burst 4 with gaps between beats.
        a_addr = 29'h100; a_burstcnt = 8'd4; a_rd = 1;
        push(K_RC, 29'h100, 8'd4, 64'h0, 8'h0);
        tick();
        chk("t2_gnt", {58'h0, outs()}, 64'b011000);
        tick();
        a_rd = 0;
        for (int i = 0; i < 4; i++) begin
            DDRAM_DOUT_READY = 0;
            repeat (1 + i % 2) tick();
            DDRAM_DOUT = 64'hA0 + 64'(i);
            DDRAM_DOUT_READY = 1;
            push(K_RA, '0, 8'd0, 64'hA0 + 64'(i), 8'h0);
            #1;
            chk($sformatf("t2_beat%0d", i), {62'h0, a_dout_ready, b_dout_ready}, 64'b10);
            tick();
        end
        DDRAM_DOUT_READY = 0;
        b_addr = 29'h120; b_burstcnt = 8'd1; b_rd = 1;
        #1;
        chk("t2_idle", {58'h0, outs()}, 64'b110000);
        tick();
        chk("t2_next_gnt", {58'h0, outs()}, 64'b101000);
        fin_rd1(1, 29'h120, 8'd1, 64'hB2);

        // B write burst 3 with a 2-cycle stall on beat 2; address must hold.
        b_addr = 29'h200; b_burstcnt = 8'd3; b_be = 8'hF0; b_we = 1; b_din = 64'hD0;
        tick();
        chk("t3_gnt", {58'h0, outs()}, 64'b100100);
        push(K_WB, 29'h200, 8'd3, 64'hD0, 8'hF0);
        tick();
        b_addr = 29'h3FF; b_burstcnt = 8'd7; b_din = 64'hD1; DDRAM_BUSY = 1;
        #1;
        chk("t3_stall1", {58'h0, outs()}, 64'b110100);
        tick();
        chk("t3_stall2", {58'h0, outs()}, 64'b110100);
        tick();
        DDRAM_BUSY = 0;
        push(K_WB, 29'h200, 8'd3, 64'hD1, 8'hF0);
        #1;
        chk("t3_beat2", {58'h0, outs()}, 64'b100100);
        tick();
        b_din = 64'hD2;
        push(K_WB, 29'h200, 8'd3, 64'hD2, 8'hF0);
        tick();
        b_we = 0;
        #1;
        chk("t3_idle", {58'h0, outs()}, 64'b110000);

        // Reset in RWAIT after one of four beats; later beats must be dropped.
        a_addr = 29'h300; a_burstcnt = 8'd4; a_rd = 1;
        push(K_RC, 29'h300, 8'd4, 64'h0, 8'h0);
        tick();
        tick();
        a_rd = 0; DDRAM_DOUT_READY = 1; DDRAM_DOUT = 64'hC0;
        push(K_RA, '0, 8'd0, 64'hC0, 8'h0);
        tick();
        DDRAM_DOUT_READY = 0; reset = 1;
        tick();
        chk("t4_rst_busy", {58'h0, outs()}, 64'b110000);
        reset = 0; DDRAM_DOUT_READY = 1;
        for (int i = 0; i < 3; i++) begin
            DDRAM_DOUT = 64'hC1 + 64'(i);
            #1;
            chk($sformatf("t4_drop%0d", i), {62'h0, a_dout_ready, b_dout_ready}, 64'b00);
            tick();
        end
        DDRAM_DOUT_READY = 0;
        a_addr = 29'h310; a_burstcnt = 8'd1; b_addr = 29'h320; b_burstcnt = 8'd1;
        a_rd = 1; b_rd = 1;
        tick();
        chk("t4_fresh_a", {58'h0, outs()}, 64'b011000);
        fin_rd1(0, 29'h310, 8'd1, 64'hC9);
        tick();
        chk("t4_then_b", {58'h0, outs()}, 64'b101000);
        fin_rd1(1, 29'h320, 8'd1, 64'hCA);

        // rd and we together: write wins, single beat.
        a_addr = 29'h400; a_burstcnt = 8'd1; a_din = 64'hD5; a_be = 8'h0F; a_rd = 1; a_we = 1;
        tick();
        chk("t5_we", {58'h0, outs()}, 64'b010100);
        push(K_WB, 29'h400, 8'd1, 64'hD5, 8'h0F);
        tick();
        a_rd = 0; a_we = 0;
        b_addr = 29'h410; b_burstcnt = 8'd1; b_rd = 1;
        #1;
        chk("t5_idle", {58'h0, outs()}, 64'b110000);
        tick();
        chk("t5_after", {58'h0, outs()}, 64'b101000);
        fin_rd1(1, 29'h410, 8'd1, 64'hD6);

        // A streams requests, B asks once: A, B, A.
        a_addr = 29'h500; a_burstcnt = 8'd1; a_rd = 1;
        tick();
        chk("t6_g1", {58'h0, outs()}, 64'b011000);
        push(K_RC, 29'h500, 8'd1, 64'h0, 8'h0);
        tick();
        b_rd = 1; b_addr = 29'h600; b_burstcnt = 8'd1; a_addr = 29'h510;
        DDRAM_DOUT_READY = 1; DDRAM_DOUT = 64'hE0;
        push(K_RA, '0, 8'd0, 64'hE0, 8'h0);
        tick();
        DDRAM_DOUT_READY = 0;
        tick();
        chk("t6_g2", {58'h0, outs()}, 64'b101000);
        fin_rd1(1, 29'h600, 8'd1, 64'hE1);
        tick();
        chk("t6_g3", {58'h0, outs()}, 64'b011000);
        fin_rd1(0, 29'h510, 8'd1, 64'hE2);

        // Burst count 0 behaves as a single beat.
        a_addr = 29'h700; a_burstcnt = 8'd0; a_rd = 1;
        tick();
        fin_rd1(0, 29'h700, 8'd0, 64'hF0);
        b_addr = 29'h710; b_burstcnt = 8'd1; b_rd = 1;
        tick();
        chk("t7_bc0_idle", {58'h0, outs()}, 64'b101000);
        fin_rd1(1, 29'h710, 8'd1, 64'hF1);

        tick();
        tick();
        chk("sb_drain", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
